dpram_rd_ctrl: RTL and testbench

Read-side controller for the 8-bit-in / 64-bit-out dual-port frame RAM. It sits directly downstream of the RAM's 64-bit port B. On a start command it streams a block of 64-bit words from a base word address onto a valid/ready output interface. It absorbs the RAM's one-cycle read latency and output back-pressure with a 2-entry buffer.

---
 rtl/dpram_rd_pkg.sv | 17 +
 rtl/rd_skid_fifo.sv | 53 +++++
 rtl/dpram_rd_ctrl.sv | 136 +++++++++++++
 tb/tb_dpram_rd_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dpram_rd_pkg.sv
// Shared types and constants for the frame-RAM read-side controller.
// Holds the default port-B geometry, the FSM state encoding and the skid depth.
// No logic lives here; it is imported by the controller and its skid FIFO.
package dpram_rd_pkg;

  localparam int DEF_ADDR_W = 13;  // 8192 words on port B
  localparam int DEF_DATA_W = 64;  // port-B word width
  localparam int DEF_CNT_W  = 14;  // block length 0..8192
  localparam int FIFO_DEPTH = 2;   // one RAM latency slot plus one back-pressure slot

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/rd_skid_fifo.sv
// 2-entry skid buffer catching port-B read data; head bypasses the write port when empty.
// Latency: a word written this cycle is visible at the head in the same cycle.
// Backpressure: never refuses a write; the caller's credit check keeps it from overflowing.
module rd_skid_fifo
  import dpram_rd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clkb,
  input  logic              rst_n,
  input  logic              wr_vld_i,
  input  logic [DATA_W-1:0] wr_dat_i,
  input  logic              pop_i,
  output logic [1:0]        cnt_o,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o
);

  // Depth is fixed at 2, so single-bit pointers toggle between the entries.
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        cnt_q;
  logic              store;
  logic              pop_stored;

  // A word that arrives into an empty buffer and is taken at once is never stored.
  always_comb begin
    store      = wr_vld_i & ~(pop_i & (cnt_q == 2'd0));
    pop_stored = pop_i & (cnt_q != 2'd0);
    head_o     = (cnt_q == 2'd0) ? wr_dat_i : mem_q[rd_ptr_q];
    empty_o    = (cnt_q == 2'd0) & ~wr_vld_i;
    cnt_o      = cnt_q;
  end

  // Storage, pointers and count; reset drops any buffered words.
  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (store) begin
        mem_q[wr_ptr_q] <= wr_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_stored) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(store) - 2'(pop_stored);
    end
  end

endmodule

// File: rtl/dpram_rd_ctrl.sv
// Streams a block of port-B words from a base address onto a valid/ready output.
// Latency: start at edge 0 -> read issued in cycle 1 -> word valid in cycle 2; done at cycle N+2.
// Backpressure: reads issue only while fewer than 2 words are held or in flight. Build option DPRAM_RD_SWAP_EN reverses bytes.
module dpram_rd_ctrl
  import dpram_rd_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clkb,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addrb,
  output logic              enb,
  input  logic [DATA_W-1:0] doutb,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] addrb_q;
  logic [CNT_W-1:0]  issue_left_q, issue_left_d;
  logic [CNT_W-1:0]  accept_left_q, accept_left_d;
  logic              enb_q;
  logic              rd_vld_q;     // port-B data on doutb this cycle
  logic              busy_q;
  logic              done_q;
  logic [1:0]        fifo_cnt;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;
  logic              pop;
  logic [2:0]        occ;
  logic              issue;
  logic [DATA_W-1:0] head_sw;

  rd_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clkb     (clkb),
    .rst_n    (rst_n),
    .wr_vld_i (rd_vld_q),
    .wr_dat_i (doutb),
    .pop_i    (pop),
    .cnt_o    (fifo_cnt),
    .head_o   (fifo_head),
    .empty_o  (fifo_empty)
  );

  // Credit: stored + arriving + being-issued words after this cycle's pop must leave room.
  always_comb begin
    pop           = m_valid & m_ready;
    occ           = 3'(fifo_cnt) + 3'(rd_vld_q) + 3'(enb_q) - 3'(pop);
    issue         = (state_q == RUN) && (issue_left_q != '0) && (occ < 3'd2);
    issue_left_d  = issue ? issue_left_q - CNT_W'(1) : issue_left_q;
    accept_left_d = pop ? accept_left_q - CNT_W'(1) : accept_left_q;
  end

  // Control FSM with registered read-port and status outputs.
  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      addrb_q       <= '0;
      issue_left_q  <= '0;
      accept_left_q <= '0;
      enb_q         <= 1'b0;
      rd_vld_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      enb_q    <= 1'b0;
      rd_vld_q <= enb_q;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (word_cnt != '0) begin
              state_q       <= RUN;
              busy_q        <= 1'b1;
              enb_q         <= 1'b1;
              addrb_q       <= base_addr;
              ptr_q         <= base_addr + ADDR_W'(1);
              issue_left_q  <= word_cnt - CNT_W'(1);
              accept_left_q <= word_cnt;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN, FLUSH: begin
          if (issue) begin
            enb_q   <= 1'b1;
            addrb_q <= ptr_q;
            ptr_q   <= ptr_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
          end
          issue_left_q  <= issue_left_d;
          accept_left_q <= accept_left_d;
          if (state_q == RUN && issue_left_d == '0) state_q <= FLUSH;
          // Last accepted word ends the block; this assignment wins over the one above.
          if (pop && accept_left_q == CNT_W'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Optional byte reversal of the head word; timing is unaffected.
  always_comb begin
    head_sw = fifo_head;
`ifdef DPRAM_RD_SWAP_EN
    for (int i = 0; i < DATA_W / 8; i++) head_sw[8*i +: 8] = fifo_head[DATA_W-8-8*i +: 8];
`endif
  end

  // Output stream; data is forced to zero while nothing is valid.
  always_comb begin
    m_valid = ~fifo_empty;
    m_data  = m_valid ? head_sw : '0;
    m_last  = m_valid & (accept_left_q == CNT_W'(1));
    busy    = busy_q;
    done    = done_q;
    addrb   = addrb_q;
    enb     = enb_q;
  end

endmodule

// File: tb/tb_dpram_rd_ctrl.sv
// Directed bench for dpram_rd_ctrl with a behavioural port-B RAM model.
// Word w of the RAM holds bytes (8w+i+1) mod 256 at bits [8i+7:8i].
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_dpram_rd_ctrl;

  logic        clkb = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [12:0] base_addr = '0;
  logic [13:0] word_cnt = '0;
  logic        busy, done, enb, m_valid, m_last;
  logic [12:0] addrb;
  logic [63:0] doutb = '0;
  logic [63:0] m_data;
  logic        m_ready = 1'b1;

  int total = 0;
  int bad = 0;

  int          addr_q[$];
  logic [63:0] data_q[$];
  int last_n, last_pos, done_cyc, enb_pre, busy1, max_held, first_vld, unstable;

  dpram_rd_ctrl dut (
    .clkb(clkb), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_cnt(word_cnt), .busy(busy), .done(done), .addrb(addrb), .enb(enb),
    .doutb(doutb), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last)
  );

  always #5 clkb = ~clkb;

  function automatic logic [63:0] ram_word(input int w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'((8*w + i + 1) & 255);
    return r;
  endfunction

  function automatic logic [63:0] exp_out(input int w);
    logic [63:0] r;
    logic [63:0] s;
    r = ram_word(w);
    s = r;
`ifdef DPRAM_RD_SWAP_EN
    for (int i = 0; i < 8; i++) s[8*i +: 8] = r[56-8*i +: 8];
`endif
    return s;
  endfunction

  // Port-B RAM: one-cycle registered read.
  always @(posedge clkb) if (enb) doutb <= ram_word(int'(addrb));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start a block at a falling edge and record one cycle per falling edge until done.
  task automatic run_block(input int base, input int cnt, input int lo_first,
                           input int lo_last, input int inj_cyc, input int max_cyc);
    int enb_n;
    int pop_n;
    addr_q.delete(); data_q.delete();
    last_n = 0; last_pos = -1; done_cyc = -1; enb_pre = 0; busy1 = -1;
    max_held = 0; first_vld = -1; unstable = 0; enb_n = 0; pop_n = 0;
    @(negedge clkb);
    start = 1'b1; base_addr = 13'(base); word_cnt = 14'(cnt); m_ready = 1'b1;
    @(posedge clkb);
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clkb);
      start = (c == inj_cyc);
      if (c == inj_cyc) begin base_addr = 13'd100; word_cnt = 14'd7; end
      m_ready = !(c >= lo_first && c <= lo_last);
      if (c == 1) busy1 = int'(busy);
      if (enb_n - pop_n > max_held) max_held = enb_n - pop_n;
      if (enb) begin
        addr_q.push_back(int'(addrb));
        enb_n++;
        if (c <= lo_last) enb_pre++;
      end
      if (m_valid && first_vld < 0) first_vld = c;
      if (m_valid && !m_ready && m_data !== exp_out((base + pop_n) % 8192)) unstable++;
      if (m_valid && m_ready) begin
        data_q.push_back(m_data);
        if (m_last) begin last_n++; last_pos = pop_n; end
        pop_n++;
      end
      if (done) begin done_cyc = c; break; end
    end
    start = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic check_words(input string tag, input int base, input int n);
    chk({tag, "_naddr"}, addr_q.size(), n);
    chk({tag, "_nword"}, data_q.size(), n);
    for (int i = 0; i < addr_q.size() && i < n; i++)
      chk({tag, "_addr"}, addr_q[i], (base + i) % 8192);
    for (int i = 0; i < data_q.size() && i < n; i++)
      chk({tag, "_data"}, data_q[i], exp_out((base + i) % 8192));
    chk({tag, "_last_n"}, last_n, 1);
    chk({tag, "_last_pos"}, last_pos, n - 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_enb"}, enb, 0);
    chk({tag, "_addrb"}, addrb, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] w0;
    repeat (2) @(negedge clkb);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clkb);

    // Basic 4-word block, sink always ready.
    run_block(0, 4, 0, -1, 0, 30);
`ifdef DPRAM_RD_SWAP_EN
    w0 = 64'h0102030405060708;
`else
    w0 = 64'h0807060504030201;
`endif
    chk("basic_word0", data_q.size() > 0 ? data_q[0] : 64'hx, w0);
    chk("basic_busy1", busy1, 1);
    chk("basic_first_vld", first_vld, 2);
    chk("basic_done_cyc", done_cyc, 6);
    check_words("basic", 0, 4);
    @(negedge clkb);
    chk("basic_busy_after", busy, 0);

    // Back-pressure: sink stalled in cycles 2..9.
    run_block(0, 6, 2, 9, 0, 60);
    chk("bp_enb_before_release", enb_pre, 2);
    chk("bp_max_held", max_held, 2);
    chk("bp_stall_data", unstable, 0);
    chk("bp_done_cyc", done_cyc, 16);
    check_words("bp", 0, 6);

    // Address wrap at the top of the RAM.
    run_block(8190, 4, 0, -1, 0, 30);
    chk("wrap_done_cyc", done_cyc, 6);
    check_words("wrap", 8190, 4);

    // Zero-length block.
    run_block(3, 0, 0, -1, 0, 10);
    chk("zero_done_cyc", done_cyc, 1);
    chk("zero_busy1", busy1, 0);
    chk("zero_nenb", addr_q.size(), 0);
    chk("zero_nword", data_q.size(), 0);

    // Start pulse while busy must be ignored.
    run_block(20, 4, 0, -1, 2, 30);
    chk("busystart_done_cyc", done_cyc, 6);
    check_words("busystart", 20, 4);

    // Reset in the middle of an 8-word block, after 2 words were accepted.
    @(negedge clkb);
    start = 1'b1; base_addr = 13'd0; word_cnt = 14'd8; m_ready = 1'b1;
    @(posedge clkb);
    @(negedge clkb); start = 1'b0;          // cycle 1
    repeat (3) @(negedge clkb);             // cycle 4: words 0 and 1 popped
    chk("midrst_busy_before", busy, 1);
    chk("midrst_data_before", m_data, exp_out(2));
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    repeat (2) @(negedge clkb);
    rst_n = 1'b1;
    @(negedge clkb);
    run_block(5, 3, 0, -1, 0, 30);
    chk("afterrst_done_cyc", done_cyc, 5);
    check_words("afterrst", 5, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
